// File: rtl/packet_filter_mc.sv
// Store-and-forward Avalon-ST filter: buffers one packet, forwards it if its channel is enabled in pass_mask_i.
// Define PACKET_FILTER_STATS_EN to add saturating forwarded/dropped packet counters.
module packet_filter_mc #(
  parameter int DWIDTH    = 64,
  parameter int EMPTY_W   = $clog2(DWIDTH/8),
  parameter int CHANNEL_W = 3,
  parameter int AWIDTH    = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [2**CHANNEL_W-1:0] pass_mask_i,
  input  logic [DWIDTH-1:0]       ast_data_i,
  input  logic                    ast_valid_i,
  input  logic                    ast_startofpacket_i,
  input  logic                    ast_endofpacket_i,
  input  logic [EMPTY_W-1:0]      ast_empty_i,
  input  logic [CHANNEL_W-1:0]    ast_channel_i,
  output logic                    ast_ready_o,
  input  logic                    ast_ready_i,
  output logic [DWIDTH-1:0]       ast_data_o,
  output logic                    ast_valid_o,
  output logic                    ast_startofpacket_o,
  output logic                    ast_endofpacket_o,
  output logic [EMPTY_W-1:0]      ast_empty_o,
`ifdef PACKET_FILTER_STATS_EN
  output logic [31:0]             pkt_pass_cnt_o,
  output logic [31:0]             pkt_drop_cnt_o,
`endif
  output logic [CHANNEL_W-1:0]    ast_channel_o
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] FULL = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, RECV, DROP, DECIDE, SEND} state_t;

  state_t               state;
  logic [DWIDTH-1:0]    mem [DEPTH];
  logic [AWIDTH:0]      wr_ptr;
  logic [AWIDTH:0]      rd_ptr;
  logic [AWIDTH-1:0]    last_idx;
  logic [CHANNEL_W-1:0] channel;
  logic [EMPTY_W-1:0]   empty;

  logic              accept;
  logic              out_xfer;
  logic              load_word;
  logic              last_word;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;

  assign accept    = ast_valid_i && ast_ready_o;
  assign out_xfer  = ast_valid_o && ast_ready_i;
  assign last_word = (rd_ptr[AWIDTH-1:0] == last_idx);
  // A new word enters the output register when it is empty or being drained this cycle.
  assign load_word = (state == SEND) && (!ast_valid_o || ast_ready_i) &&
                     (rd_ptr <= {1'b0, last_idx});

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    if (accept && state != DECIDE && state != SEND) begin
      if (ast_startofpacket_i) begin
        mem_we = 1'b1;
      end else if (state == RECV && wr_ptr != FULL) begin
        mem_we    = 1'b1;
        mem_waddr = wr_ptr[AWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= ast_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      last_idx            <= '0;
      channel             <= '0;
      empty               <= '0;
      ast_ready_o         <= 1'b0;
      ast_valid_o         <= 1'b0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_data_o          <= '0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else begin
      case (state)
        IDLE, RECV, DROP: begin
          ast_ready_o <= 1'b1;
          if (accept) begin
            if (ast_startofpacket_i) begin
              channel <= ast_channel_i;
              wr_ptr  <= (AWIDTH+1)'(1);
              if (ast_endofpacket_i) begin
                empty       <= ast_empty_i;
                last_idx    <= '0;
                state       <= DECIDE;
                ast_ready_o <= 1'b0;
              end else begin
                state <= RECV;
              end
            end else if (state == RECV) begin
              // The beat after a full buffer is never stored; an EOP on it ends the drop at once.
              if (wr_ptr == FULL) begin
                state <= ast_endofpacket_i ? IDLE : DROP;
              end else begin
                wr_ptr <= wr_ptr + (AWIDTH+1)'(1);
                if (ast_endofpacket_i) begin
                  empty       <= ast_empty_i;
                  last_idx    <= wr_ptr[AWIDTH-1:0];
                  state       <= DECIDE;
                  ast_ready_o <= 1'b0;
                end
              end
            end else if (state == DROP && ast_endofpacket_i) begin
              state <= IDLE;
            end
          end
        end
        DECIDE: begin
          rd_ptr <= '0;
          if (pass_mask_i[channel]) begin
            state         <= SEND;
            ast_channel_o <= channel;
          end else begin
            state       <= IDLE;
            ast_ready_o <= 1'b1;
          end
        end
        SEND: begin
          if (load_word) begin
            ast_data_o          <= mem[rd_ptr[AWIDTH-1:0]];
            ast_valid_o         <= 1'b1;
            ast_startofpacket_o <= (rd_ptr == '0);
            ast_endofpacket_o   <= last_word;
            ast_empty_o         <= last_word ? empty : '0;
            rd_ptr              <= rd_ptr + (AWIDTH+1)'(1);
          end else if (out_xfer) begin
            ast_valid_o         <= 1'b0;
            ast_startofpacket_o <= 1'b0;
            ast_endofpacket_o   <= 1'b0;
            ast_empty_o         <= '0;
          end
          if (out_xfer && ast_endofpacket_o) begin
            state       <= IDLE;
            ast_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          ast_ready_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACKET_FILTER_STATS_EN
  logic drop_evt;
  logic pass_evt;

  // Restarts and overflows are dropped on the accepted beat; mask drops in the decision cycle.
  assign drop_evt = (state == RECV && accept && (ast_startofpacket_i || wr_ptr == FULL)) ||
                    (state == DECIDE && !pass_mask_i[channel]);
  assign pass_evt = (state == SEND) && out_xfer && ast_endofpacket_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_pass_cnt_o <= '0;
      pkt_drop_cnt_o <= '0;
    end else begin
      if (pass_evt && pkt_pass_cnt_o != 32'hFFFF_FFFF) pkt_pass_cnt_o <= pkt_pass_cnt_o + 32'd1;
      if (drop_evt && pkt_drop_cnt_o != 32'hFFFF_FFFF) pkt_drop_cnt_o <= pkt_drop_cnt_o + 32'd1;
    end
  end
`else
  // Statistics build option off: no counter state is kept.
`endif

endmodule

// File: tb/tb_packet_filter_mc.sv
// Self-checking bench for packet_filter_mc (AWIDTH=3, so DEPTH=8); packet-level reference model.
// Counter checks are compiled in when PACKET_FILTER_STATS_EN is defined.
module tb_packet_filter_mc;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  em;
    logic [2:0]  ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pass_mask = 8'h00;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [2:0]  in_empty = '0;
  logic [2:0]  in_channel = '0;
  logic        in_ready;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_empty;
  logic [2:0]  out_channel;
`ifdef PACKET_FILTER_STATS_EN
  logic [31:0] pass_cnt;
  logic [31:0] drop_cnt;
`endif

  logic        sink_random = 1'b0;
  logic        sink_fixed = 1'b1;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] last_words[$];
  beat_t       got[$];
  beat_t       exp_q[$];

  packet_filter_mc #(.DWIDTH(64), .CHANNEL_W(3), .AWIDTH(3)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .pass_mask_i         (pass_mask),
    .ast_data_i          (in_data),
    .ast_valid_i         (in_valid),
    .ast_startofpacket_i (in_sop),
    .ast_endofpacket_i   (in_eop),
    .ast_empty_i         (in_empty),
    .ast_channel_i       (in_channel),
    .ast_ready_o         (in_ready),
    .ast_ready_i         (out_ready),
    .ast_data_o          (out_data),
    .ast_valid_o         (out_valid),
    .ast_startofpacket_o (out_sop),
    .ast_endofpacket_o   (out_eop),
    .ast_empty_o         (out_empty),
`ifdef PACKET_FILTER_STATS_EN
    .pkt_pass_cnt_o      (pass_cnt),
    .pkt_drop_cnt_o      (drop_cnt),
`endif
    .ast_channel_o       (out_channel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = sink_random ? ($urandom_range(0, 3) != 0) : sink_fixed;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got.push_back(beat_t'({out_data, out_sop, out_eop, out_empty, out_channel}));
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] em, input logic [2:0] ch);
    bit acc;
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_channel = ch; in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL drive_timeout: sink ready stayed 0 for 400 cycles, want 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input int len, input logic [2:0] ch, input logic [2:0] em, input int max_gap);
    logic [63:0] w;
    last_words.delete();
    for (int i = 0; i < len; i++) begin
      w = {$urandom, $urandom};
      last_words.push_back(w);
      drive_beat(w, i == 0, i == len - 1, (i == len - 1) ? em : 3'($urandom), (i == 0) ? ch : 3'($urandom));
      if (i != len - 1 && max_gap > 0)
        repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic expect_packet(input logic [2:0] ch, input logic [2:0] em);
    beat_t b;
    for (int i = 0; i < last_words.size(); i++) begin
      b.d   = last_words[i];
      b.sop = (i == 0);
      b.eop = (i == last_words.size() - 1);
      b.em  = b.eop ? em : 3'd0;
      b.ch  = ch;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (got.size() >= exp_q.size() && in_ready && !out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({in_ready, out_valid, out_sop, out_eop} !== 4'b0000) $display("FAIL reset_flags: got ready/valid/sop/eop %b want 0000", {in_ready, out_valid, out_sop, out_eop}); else n_pass++;
    n_checks++; if ({out_data, out_empty, out_channel} !== 70'd0) $display("FAIL reset_fields: got data %h empty %0d ch %0d want 0 0 0", out_data, out_empty, out_channel); else n_pass++;
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if ({pass_cnt, drop_cnt} !== 64'd0) $display("FAIL reset_counts: got %0d %0d want 0 0", pass_cnt, drop_cnt); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_first_edge_ready: got %b want 1", in_ready); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [72:0] have, want;
`ifdef PACKET_FILTER_STATS_EN
    logic [31:0] pc0 = pass_cnt;
`endif
    got.delete(); pass_mask = 8'h04; sink_random = 1'b0; sink_fixed = 1'b1;
    send_packet(4, 3'd2, 3'd3, 0);
    n_checks++; if ({in_ready, out_valid} !== 2'b00) $display("FAIL basic_decide: got ready/valid %b want 00", {in_ready, out_valid}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", out_valid); else n_pass++;
    for (int w = 0; w < 4; w++) begin
      @(posedge clk); #1;
      have = {out_valid, out_data, out_sop, out_eop, out_empty, out_channel};
      want = {1'b1, last_words[w], w == 0, w == 3, (w == 3) ? 3'd3 : 3'd0, 3'd2};
      n_checks++; if (have !== want) $display("FAIL basic_word%0d: got %h want %h", w, have, want); else n_pass++;
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_after_eop: got ready/valid %b want 10", {in_ready, out_valid}); else n_pass++;
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if (pass_cnt !== pc0 + 32'd1) $display("FAIL basic_pass_cnt: got %0d want %0d", pass_cnt, pc0 + 32'd1); else n_pass++;
`endif
    $display("test_basic: 4-word packet ch 2 forwarded");
  endtask

  task automatic test_mask_drop();
    logic saw_valid = 1'b0;
`ifdef PACKET_FILTER_STATS_EN
    logic [31:0] dc0 = drop_cnt;
`endif
    got.delete(); pass_mask = 8'hFB; sink_fixed = 1'b1;
    send_packet(4, 3'd2, 3'd3, 0);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL drop_decide_ready: got %b want 0", in_ready); else n_pass++;
    saw_valid = out_valid;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL drop_idle_ready: got %b want 1", in_ready); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      saw_valid = saw_valid | out_valid;
      @(posedge clk); #1;
    end
    n_checks++; if ({saw_valid, in_ready} !== 2'b01) $display("FAIL drop_quiet: got valid_seen/ready %b want 01", {saw_valid, in_ready}); else n_pass++;
    n_checks++; if (got.size() !== 0) $display("FAIL drop_no_beats: got %0d beats want 0", got.size()); else n_pass++;
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if (drop_cnt !== dc0 + 32'd1) $display("FAIL drop_cnt_mask: got %0d want %0d", drop_cnt, dc0 + 32'd1); else n_pass++;
`endif
    $display("test_mask_drop: 4-word packet ch 2 discarded");
  endtask

  task automatic test_oversize();
    bit ok;
    logic saw_valid = 1'b0;
`ifdef PACKET_FILTER_STATS_EN
    logic [31:0] dc0;
`endif
    got.delete(); exp_q.delete(); pass_mask = 8'hFF; sink_fixed = 1'b1;
    send_packet(DEPTH, 3'd7, 3'd0, 0);
    expect_packet(3'd7, 3'd0);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL full_drain: timed out with %0d beats, want %0d", got.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got.size() !== exp_q.size()) $display("FAIL full_count: got %0d beats want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL full_beat%0d: got %h want %h", i, got[i], exp_q[i]); else n_pass++;
    end
    $display("test_oversize: %0d-word packet forwarded", DEPTH);
    got.delete(); exp_q.delete();
`ifdef PACKET_FILTER_STATS_EN
    dc0 = drop_cnt;
`endif
    send_packet(DEPTH + 1, 3'd1, 3'd4, 0);
    n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL over_idle: got ready/valid %b want 10", {in_ready, out_valid}); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      saw_valid = saw_valid | out_valid;
      @(posedge clk); #1;
    end
    n_checks++; if (saw_valid !== 1'b0 || got.size() !== 0) $display("FAIL over_output: got valid_seen %b beats %0d want 0 0", saw_valid, got.size()); else n_pass++;
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if (drop_cnt !== dc0 + 32'd1) $display("FAIL over_drop_cnt: got %0d want %0d", drop_cnt, dc0 + 32'd1); else n_pass++;
`endif
    $display("test_oversize: %0d-word packet discarded", DEPTH + 1);
  endtask

  task automatic test_single_beat();
    logic [63:0] d = {$urandom, $urandom};
    logic [72:0] have, want;
    got.delete(); pass_mask = 8'hFF; sink_fixed = 1'b0;
    drive_beat(d, 1'b1, 1'b1, 3'd7, 3'd4);
    repeat (2) begin @(posedge clk); #1; end
    want = {1'b1, d, 1'b1, 1'b1, 3'd7, 3'd4};
    for (int k = 0; k < 3; k++) begin
      have = {out_valid, out_data, out_sop, out_eop, out_empty, out_channel};
      n_checks++; if (have !== want) $display("FAIL single_hold%0d: got %h want %h", k, have, want); else n_pass++;
      if (k < 2) begin @(posedge clk); #1; end
    end
    sink_fixed = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || got.size() !== 1) $display("FAIL single_done: got valid %b beats %0d want 0 1", out_valid, got.size()); else n_pass++;
    $display("test_single_beat: 1-beat packet ch 4 forwarded after stall");
  endtask

  task automatic test_restart();
    bit ok;
`ifdef PACKET_FILTER_STATS_EN
    logic [31:0] dc0 = drop_cnt;
`endif
    got.delete(); exp_q.delete(); pass_mask = 8'h02; sink_fixed = 1'b1;
    drive_beat({$urandom, $urandom}, 1'b0, 1'b1, 3'd2, 3'd1);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'd0, 3'd6);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'd0, 3'd1);
    send_packet(4, 3'd1, 3'd5, 1);
    expect_packet(3'd1, 3'd5);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL restart_drain: timed out with %0d beats, want %0d", got.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got.size() !== exp_q.size()) $display("FAIL restart_count: got %0d beats want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL restart_beat%0d: got %h want %h", i, got[i], exp_q[i]); else n_pass++;
    end
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if (drop_cnt !== dc0 + 32'd1) $display("FAIL restart_drop_cnt: got %0d want %0d", drop_cnt, dc0 + 32'd1); else n_pass++;
`endif
    $display("test_restart: partial packet replaced, 4-word ch 1 forwarded");
  endtask

  task automatic test_reset_mid();
    bit ok;
    got.delete(); exp_q.delete(); pass_mask = 8'hFF; sink_fixed = 1'b1;
    send_packet(4, 3'd3, 3'd2, 0);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if ({out_valid, out_data} !== {1'b1, last_words[1]}) $display("FAIL midrst_word1: got valid %b data %h want 1 %h", out_valid, out_data, last_words[1]); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({in_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_channel} !== 74'd0) $display("FAIL midrst_outputs: got ready %b valid %b data %h ch %0d want all 0", in_ready, out_valid, out_data, out_channel); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_glitch: got valid %b want 0", out_valid); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL midrst_recover: got ready/valid %b want 10", {in_ready, out_valid}); else n_pass++;
    send_packet(3, 3'd5, 3'd1, 1);
    expect_packet(3'd5, 3'd1);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL midrst_drain: timed out with %0d beats, want %0d", got.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got.size() !== exp_q.size()) $display("FAIL midrst_count: got %0d beats want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL midrst_beat%0d: got %h want %h", i, got[i], exp_q[i]); else n_pass++;
    end
    $display("test_reset_mid: reset during send, fresh 3-word packet forwarded");
  endtask

  task automatic test_random();
    bit ok;
    int len;
    logic [2:0] ch, em;
    bit fwd;
`ifdef PACKET_FILTER_STATS_EN
    logic [31:0] pc0 = pass_cnt, dc0 = drop_cnt;
    int n_fwd = 0, n_drop = 0;
`endif
    got.delete(); exp_q.delete(); sink_random = 1'b1;
    pass_mask = 8'($urandom);
    for (int p = 0; p < 16; p++) begin
      len = $urandom_range(1, DEPTH + 2);
      ch  = 3'($urandom);
      em  = 3'($urandom);
      fwd = (len <= DEPTH) && pass_mask[ch];
      send_packet(len, ch, em, 2);
      if (fwd) expect_packet(ch, em);
`ifdef PACKET_FILTER_STATS_EN
      if (fwd) n_fwd++; else n_drop++;
`endif
      $display("random pkt %0d: len %0d ch %0d mask %02h -> %s", p, len, ch, pass_mask, fwd ? "forward" : "discard");
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL rand_drain: timed out with %0d beats, want %0d", got.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got.size() !== exp_q.size()) $display("FAIL rand_count: got %0d beats want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h want %h", i, got[i], exp_q[i]); else n_pass++;
    end
`ifdef PACKET_FILTER_STATS_EN
    n_checks++; if (pass_cnt - pc0 !== 32'(n_fwd)) $display("FAIL rand_pass_cnt: got +%0d want +%0d", pass_cnt - pc0, n_fwd); else n_pass++;
    n_checks++; if (drop_cnt - dc0 !== 32'(n_drop)) $display("FAIL rand_drop_cnt: got +%0d want +%0d", drop_cnt - dc0, n_drop); else n_pass++;
`endif
    sink_random = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_drop();
    test_oversize();
    test_single_beat();
    test_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
